// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if
// Bundles the receive-side stream and the status outputs of the LFSR checker.
//   clr        : synchronous clear of the error/word counters
//   data_valid : data_in holds a received word this cycle
//   data_in    : received 8-bit LFSR word
//   locked     : checker is tracking the sequence
//   err_pulse  : one-cycle pulse per mismatching word while locked
//   err_count  : saturating mismatch count while locked
//   word_count : saturating count of words compared while locked
//   expected   : predicted value of the next word
// The master modport drives the stream; the slave modport is the checker.
interface lfsr_checker_if;
  logic        clr;
  logic        data_valid;
  logic [7:0]  data_in;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] word_count;
  logic [7:0]  expected;

  modport master (
    output clr, data_valid, data_in,
    input  locked, err_pulse, err_count, word_count, expected
  );

  modport slave (
    input  clr, data_valid, data_in,
    output locked, err_pulse, err_count, word_count, expected
  );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker
// Synchronises to an incoming 8-bit LFSR word stream, declares lock after
// LOCK_COUNT consecutive correct predictions and then counts words and
// mismatches; MAX_ERR consecutive mismatches drop lock.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lfsr_checker_if.slave (stream inputs, status outputs)
module lfsr_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MAX_ERR    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  lfsr_checker_if.slave bus
);

  typedef enum logic [1:0] {SEEK, SYNC, LOCKED} state_e;

  state_e      state_q, state_d;
  logic [7:0]  expected_q, expected_d;
  logic [3:0]  syncCnt_q, syncCnt_d;
  logic [3:0]  missCnt_q, missCnt_d;
  logic [15:0] errCount_q, errCount_d;
  logic [15:0] wordCount_q, wordCount_d;
  logic        locked_q, locked_d;
  logic        errPulse_q, errPulse_d;
  logic        wordMatch;

  // One step of the 8-bit LFSR the transmitter uses (taps 7,5,4,3).
  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  assign wordMatch = (bus.data_in == expected_q);

  // State register: every piece of state, including the registered
  // outputs, is cleared immediately when rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEEK;
      expected_q  <= 8'h00;
      syncCnt_q   <= 4'd0;
      missCnt_q   <= 4'd0;
      errCount_q  <= 16'd0;
      wordCount_q <= 16'd0;
      locked_q    <= 1'b0;
      errPulse_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      syncCnt_q   <= syncCnt_d;
      missCnt_q   <= missCnt_d;
      errCount_q  <= errCount_d;
      wordCount_q <= wordCount_d;
      locked_q    <= locked_d;
      errPulse_q  <= errPulse_d;
    end
  end

  // Next-state and datapath logic. Nothing moves unless a valid word is
  // presented. While locked the prediction free-runs from expected_q so a
  // corrupted word cannot pull the checker off the true sequence.
  always_comb begin
    logic incErr;
    logic incWord;
    state_d    = state_q;
    expected_d = expected_q;
    syncCnt_d  = syncCnt_q;
    missCnt_d  = missCnt_q;
    incErr     = 1'b0;
    incWord    = 1'b0;

    if (bus.data_valid) begin
      unique case (state_q)
        SEEK: begin
          // 0x00 is the LFSR lock-up state and can never seed a sequence.
          if (bus.data_in != 8'h00) begin
            expected_d = nxt(bus.data_in);
            syncCnt_d  = 4'd0;
            state_d    = SYNC;
          end
        end
        SYNC: begin
          if (wordMatch) begin
            syncCnt_d  = syncCnt_q + 4'd1;
            expected_d = nxt(expected_q);
            if (syncCnt_q + 4'd1 == 4'(LOCK_COUNT)) begin
              state_d   = LOCKED;
              missCnt_d = 4'd0;
            end
          end else if (bus.data_in != 8'h00) begin
            expected_d = nxt(bus.data_in);
            syncCnt_d  = 4'd0;
          end else begin
            state_d = SEEK;
          end
        end
        LOCKED: begin
          expected_d = nxt(expected_q);
          incWord    = 1'b1;
          if (wordMatch) begin
            missCnt_d = 4'd0;
          end else begin
            incErr    = 1'b1;
            missCnt_d = missCnt_q + 4'd1;
            if (missCnt_q + 4'd1 == 4'(MAX_ERR)) begin
              state_d = SEEK;
            end
          end
        end
        default: state_d = SEEK;
      endcase
    end

    // clr wins over a same-cycle increment; both counters stick at 0xFFFF.
    errCount_d  = errCount_q;
    wordCount_d = wordCount_q;
    if (bus.clr) begin
      errCount_d  = 16'd0;
      wordCount_d = 16'd0;
    end else begin
      if (incErr && errCount_q != 16'hFFFF) begin
        errCount_d = errCount_q + 16'd1;
      end
      if (incWord && wordCount_q != 16'hFFFF) begin
        wordCount_d = wordCount_q + 16'd1;
      end
    end
  end

  // Output logic: locked follows the state being entered, and the error
  // pulse flags a mismatch accepted while locked; both are registered.
  always_comb begin
    locked_d   = (state_d == LOCKED);
    errPulse_d = bus.data_valid && (state_q == LOCKED) && !wordMatch;
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = errPulse_q;
  assign bus.err_count  = errCount_q;
  assign bus.word_count = wordCount_q;
  assign bus.expected   = expected_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
// Self-checking bench for lfsr_checker: a table of hand-computed vectors,
// hand-written reset/clear corner sequences, then randomized traffic
// compared against a behavioural model of the checker.
module tb_lfsr_checker;

  localparam int LOCK_N = 4;
  localparam int MISS_N = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lfsr_checker_if busIf ();

  lfsr_checker #(
    .LOCK_COUNT(LOCK_N),
    .MAX_ERR   (MISS_N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busIf)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        valid;
    logic [7:0]  data;
    logic        wantLocked;
    logic        wantPulse;
    logic [15:0] wantErrs;
    logic [15:0] wantWords;
    logic [7:0]  wantExp;
  } vec_t;

  vec_t vecs[19];

  // Behavioural model: the phase the checker is in, how many correct
  // predictions in a row, how many misses in a row, plus the visible values.
  string mPhase;
  int    mExp;
  int    mRun;
  int    mMiss;
  int    mErrs;
  int    mWords;
  bit    mPulse;

  // Next LFSR value from arithmetic: shift left, append parity of taps.
  function automatic int lfsrNext(input int s);
    return ((s * 2) % 256) + ($countones(s & 8'hB8) % 2);
  endfunction

  function automatic int bump(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic modelReset();
    mPhase = "seek";
    mExp   = 0;
    mRun   = 0;
    mMiss  = 0;
    mErrs  = 0;
    mWords = 0;
    mPulse = 1'b0;
  endtask

  task automatic modelStep(input bit c, input bit v, input int d);
    mPulse = 1'b0;
    if (v) begin
      if (mPhase == "seek") begin
        if (d != 0) begin
          mExp   = lfsrNext(d);
          mRun   = 0;
          mPhase = "sync";
        end
      end else if (mPhase == "sync") begin
        if (d == mExp) begin
          mRun = mRun + 1;
          mExp = lfsrNext(mExp);
          if (mRun == LOCK_N) begin
            mPhase = "locked";
            mMiss  = 0;
          end
        end else if (d != 0) begin
          mExp = lfsrNext(d);
          mRun = 0;
        end else begin
          mPhase = "seek";
        end
      end else begin
        mWords = bump(mWords);
        if (d != mExp) begin
          mPulse = 1'b1;
          mErrs  = bump(mErrs);
          mMiss  = mMiss + 1;
          if (mMiss == MISS_N) mPhase = "seek";
        end else begin
          mMiss = 0;
        end
        mExp = lfsrNext(mExp);
      end
    end
    if (c) begin
      mErrs  = 0;
      mWords = 0;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int want);
    checks++;
    if (actual != want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, want, $time);
    end
  endtask

  task automatic checkAllAgainstModel(input string tag);
    checkOutput({tag, ".locked"},     int'(busIf.locked),     int'(mPhase == "locked"));
    checkOutput({tag, ".err_pulse"},  int'(busIf.err_pulse),  int'(mPulse));
    checkOutput({tag, ".err_count"},  int'(busIf.err_count),  mErrs);
    checkOutput({tag, ".word_count"}, int'(busIf.word_count), mWords);
    checkOutput({tag, ".expected"},   int'(busIf.expected),   mExp);
  endtask

  // Drive one cycle of inputs, let the model see the same edge, then
  // sample one unit after the edge.
  task automatic applyStimulus(input bit c, input bit v, input logic [7:0] d);
    busIf.clr        = c;
    busIf.data_valid = v;
    busIf.data_in    = d;
    @(posedge clk);
    modelStep(c, v, int'(d));
    #1;
  endtask

  task automatic doReset();
    busIf.clr        = 1'b0;
    busIf.data_valid = 1'b0;
    busIf.data_in    = 8'h00;
    rst_n            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic sendLockSequence();
    applyStimulus(1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h02);
    applyStimulus(1'b0, 1'b1, 8'h04);
    applyStimulus(1'b0, 1'b1, 8'h08);
    applyStimulus(1'b0, 1'b1, 8'h11);
  endtask

  function automatic vec_t mk(input logic c, input logic v, input logic [7:0] d,
                              input logic l, input logic p, input logic [15:0] e,
                              input logic [15:0] w, input logic [7:0] x);
    vec_t r;
    r.clr = c; r.valid = v; r.data = d;
    r.wantLocked = l; r.wantPulse = p; r.wantErrs = e; r.wantWords = w; r.wantExp = x;
    return r;
  endfunction

  initial begin
    logic [7:0] rd;
    bit         rv;
    bit         rc;
    checks = 0;
    errors = 0;

    // Lock on 01,02,04,08,11; track; one isolated error; three in a row to
    // lose lock; zero ignored in seek; idle; resync and reseed; clear.
    vecs[0]  = mk(0, 1, 8'h01, 0, 0, 0, 0, 8'h02);
    vecs[1]  = mk(0, 1, 8'h02, 0, 0, 0, 0, 8'h04);
    vecs[2]  = mk(0, 1, 8'h04, 0, 0, 0, 0, 8'h08);
    vecs[3]  = mk(0, 1, 8'h08, 0, 0, 0, 0, 8'h11);
    vecs[4]  = mk(0, 1, 8'h11, 1, 0, 0, 0, 8'h23);
    vecs[5]  = mk(0, 1, 8'h23, 1, 0, 0, 1, 8'h47);
    vecs[6]  = mk(0, 1, 8'h47, 1, 0, 0, 2, 8'h8E);
    vecs[7]  = mk(0, 1, 8'h8E, 1, 0, 0, 3, 8'h1C);
    vecs[8]  = mk(0, 1, 8'h00, 1, 1, 1, 4, 8'h38);
    vecs[9]  = mk(0, 1, 8'h38, 1, 0, 1, 5, 8'h71);
    vecs[10] = mk(0, 1, 8'h00, 1, 1, 2, 6, 8'hE2);
    vecs[11] = mk(0, 1, 8'h00, 1, 1, 3, 7, 8'hC4);
    vecs[12] = mk(0, 1, 8'h00, 0, 1, 4, 8, 8'h89);
    vecs[13] = mk(0, 1, 8'h00, 0, 0, 4, 8, 8'h89);
    vecs[14] = mk(0, 0, 8'h5A, 0, 0, 4, 8, 8'h89);
    vecs[15] = mk(0, 1, 8'h01, 0, 0, 4, 8, 8'h02);
    vecs[16] = mk(0, 1, 8'h02, 0, 0, 4, 8, 8'h04);
    vecs[17] = mk(0, 1, 8'h55, 0, 0, 4, 8, 8'hAB);
    vecs[18] = mk(1, 0, 8'h00, 0, 0, 0, 0, 8'hAB);

    doReset();
    checkAllAgainstModel("reset");

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("vec%0d.locked", i),     int'(busIf.locked),     int'(vecs[i].wantLocked));
      checkOutput($sformatf("vec%0d.err_pulse", i),  int'(busIf.err_pulse),  int'(vecs[i].wantPulse));
      checkOutput($sformatf("vec%0d.err_count", i),  int'(busIf.err_count),  int'(vecs[i].wantErrs));
      checkOutput($sformatf("vec%0d.word_count", i), int'(busIf.word_count), int'(vecs[i].wantWords));
      checkOutput($sformatf("vec%0d.expected", i),   int'(busIf.expected),   int'(vecs[i].wantExp));
    end

    // Async reset mid-sync, asserted between clock edges.
    doReset();
    applyStimulus(1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h02);
    applyStimulus(1'b0, 1'b1, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncSync.expected", int'(busIf.expected), 0);
    checkOutput("asyncSync.locked",   int'(busIf.locked),   0);
    #1;
    rst_n = 1'b1;
    modelReset();
    // First valid word after reset release seeds straight away.
    applyStimulus(1'b0, 1'b1, 8'h04);
    checkAllAgainstModel("postReset");

    // Clear with a same-cycle mismatch while locked.
    doReset();
    sendLockSequence();
    applyStimulus(1'b0, 1'b1, 8'h23);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    checkOutput("clrMiss.err_count",  int'(busIf.err_count),  0);
    checkOutput("clrMiss.word_count", int'(busIf.word_count), 0);
    checkOutput("clrMiss.err_pulse",  int'(busIf.err_pulse),  1);
    checkOutput("clrMiss.locked",     int'(busIf.locked),     1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("clrMiss.pulseDrop",  int'(busIf.err_pulse),  0);

    // Async reset while locked with non-zero counters.
    applyStimulus(1'b0, 1'b1, 8'h00);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncLocked.locked",     int'(busIf.locked),     0);
    checkOutput("asyncLocked.err_count",  int'(busIf.err_count),  0);
    checkOutput("asyncLocked.word_count", int'(busIf.word_count), 0);
    checkOutput("asyncLocked.err_pulse",  int'(busIf.err_pulse),  0);
    #1;
    rst_n = 1'b1;
    modelReset();

    // Randomized traffic, biased towards the predicted word so the checker
    // repeatedly locks, tracks, takes errors and loses lock.
    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(0, 9) < 8);
      rc = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) < 8) rd = 8'(mExp);
      else if ($urandom_range(0, 3) == 0) rd = 8'h00;
      else rd = 8'($urandom_range(0, 255));
      if (mPhase == "seek" && rd == 8'h00 && $urandom_range(0, 1) == 1) begin
        rd = 8'($urandom_range(1, 255));
      end
      applyStimulus(rc, rv, rd);
      checkAllAgainstModel("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
